// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer and datapath:
// controller states, per-step arithmetic op encoding, mode constants and the
// per-step op decision helpers for Booth multiply and non-restoring divide.
package multdiv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } op_e;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    // Radix-2 Booth recoding of the current and previous multiplier bits.
    function automatic op_e booth_op(input logic q0, input logic q_m1);
        op_e op;
        case ({q0, q_m1})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

    // Non-restoring divide: the first step always subtracts, later steps
    // add back when the partial remainder went negative.
    function automatic op_e nonrestore_op(input logic first_step, input logic msb);
        op_e op;
        if (first_step) begin
            op = OP_SUB;
        end else if (msb) begin
            op = OP_ADD;
        end else begin
            op = OP_SUB;
        end
        return op;
    endfunction

endpackage

// File: rtl/md_step_counter.sv
// Iteration step counter. Cleared while operands load, advances once per
// iteration and saturates at the final step so it can never wrap.
module md_step_counter #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] step,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] step_r;
    logic             last_s;

    assign last_s = (step_r == LAST_STEP);

    // Step register: clear on load, count while enabled, hold at the last step.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            step_r <= {CNT_W{1'b0}};
        end else if (enable && !last_s) begin
            step_r <= step_r + ONE;
        end else begin
            step_r <= step_r;
        end
    end

    assign step = step_r;
    assign last = last_s;

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// Sequencer for the shared iterative multiply/divide datapath. Runs WIDTH
// Booth-multiply or non-restoring-divide steps, a remainder restore step for
// divide, and short-circuits divide-by-zero straight to completion.
module multdiv_seq_ctrl
    import multdiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             divisor_zero,
    input  logic             q0,
    input  logic             q_m1,
    input  logic             msb,
    output logic             load,
    output logic             add,
    output logic             sub,
    output logic             nop,
    output logic             shift,
    output logic             restore,
    output logic             busy,
    output logic             ready,
    output logic             div_by_zero,
    output logic [CNT_W-1:0] step
);

    state_e           state_r;
    logic             mode_r;
    logic             dbz_r;
    logic             load_r;
    logic             busy_r;
    logic             shift_r;
    logic             ready_r;
    logic [CNT_W-1:0] step_s;
    logic             last_s;
    logic             clear_s;
    logic             enable_s;
    op_e              op_s;

    assign clear_s  = (state_r == LOAD);
    assign enable_s = (state_r == RUN);

    md_step_counter #(.WIDTH(WIDTH)) u_step_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear_s),
        .enable  (enable_s),
        .step    (step_s),
        .last    (last_s)
    );

    // Controller FSM; state-only strobes are registered from the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            mode_r  <= MODE_MUL;
            dbz_r   <= 1'b0;
            load_r  <= 1'b0;
            busy_r  <= 1'b0;
            shift_r <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r <= LOAD;
                        mode_r  <= is_div;
                        dbz_r   <= is_div & divisor_zero;
                        load_r  <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        load_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                    shift_r <= 1'b0;
                    ready_r <= 1'b0;
                end
                LOAD: begin
                    load_r <= 1'b0;
                    if (dbz_r) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        shift_r <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        shift_r <= 1'b1;
                        ready_r <= 1'b0;
                    end
                end
                RUN: begin
                    load_r <= 1'b0;
                    if (last_s) begin
                        shift_r <= 1'b0;
                        if (mode_r == MODE_DIV) begin
                            state_r <= FIXUP;
                            busy_r  <= 1'b1;
                            ready_r <= 1'b0;
                        end else begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            ready_r <= 1'b1;
                        end
                    end else begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        shift_r <= 1'b1;
                        ready_r <= 1'b0;
                    end
                end
                FIXUP: begin
                    state_r <= DONE;
                    load_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    shift_r <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    load_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    shift_r <= 1'b0;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Per-step arithmetic op, only meaningful while iterating.
    always_comb begin
        op_s = OP_NOP;
        if (state_r == RUN) begin
            if (mode_r == MODE_DIV) begin
                op_s = nonrestore_op(step_s == {CNT_W{1'b0}}, msb);
            end else begin
                op_s = booth_op(q0, q_m1);
            end
        end else begin
            op_s = OP_NOP;
        end
    end

    assign load        = load_r;
    assign busy        = busy_r;
    assign shift       = shift_r;
    assign ready       = ready_r;
    assign div_by_zero = dbz_r;
    assign step        = step_s;
    assign add         = (op_s == OP_ADD);
    assign sub         = (op_s == OP_SUB);
    assign nop         = (state_r == RUN) && (op_s == OP_NOP);
    assign restore     = (state_r == FIXUP) && msb;

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// Randomized self-checking bench for multdiv_seq_ctrl. The main instance is
// WIDTH=8; WIDTH=5 and WIDTH=32 instances share inputs for latency checks.
module tb_multdiv_seq_ctrl;

    localparam int W = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0, is_div = 1'b0, divisor_zero = 1'b0;
    logic q0 = 1'b0, q_m1 = 1'b0, msb = 1'b0;

    logic load, add, sub, nop, shift, restore, busy, ready, div_by_zero;
    logic [2:0] step;
    logic load5, add5, sub5, nop5, shift5, restore5, busy5, ready5, dbz5;
    logic [2:0] step5;
    logic load32, add32, sub32, nop32, shift32, restore32, busy32, ready32, dbz32;
    logic [4:0] step32;

    int  n_cmp = 0;
    int  n_bad = 0;
    logic exp_dbz = 1'b0;

    multdiv_seq_ctrl #(.WIDTH(W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .is_div(is_div),
        .divisor_zero(divisor_zero), .q0(q0), .q_m1(q_m1), .msb(msb),
        .load(load), .add(add), .sub(sub), .nop(nop), .shift(shift),
        .restore(restore), .busy(busy), .ready(ready),
        .div_by_zero(div_by_zero), .step(step)
    );

    multdiv_seq_ctrl #(.WIDTH(5)) dut5 (
        .clock(clock), .reset_n(reset_n), .start(start), .is_div(is_div),
        .divisor_zero(divisor_zero), .q0(q0), .q_m1(q_m1), .msb(msb),
        .load(load5), .add(add5), .sub(sub5), .nop(nop5), .shift(shift5),
        .restore(restore5), .busy(busy5), .ready(ready5),
        .div_by_zero(dbz5), .step(step5)
    );

    multdiv_seq_ctrl #(.WIDTH(32)) dut32 (
        .clock(clock), .reset_n(reset_n), .start(start), .is_div(is_div),
        .divisor_zero(divisor_zero), .q0(q0), .q_m1(q_m1), .msb(msb),
        .load(load32), .add(add32), .sub(sub32), .nop(nop32), .shift(shift32),
        .restore(restore32), .busy(busy32), .ready(ready32),
        .div_by_zero(dbz32), .step(step32)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic e_load, input logic e_add, input logic e_sub,
                                 input logic e_nop, input logic e_shift, input logic e_restore,
                                 input logic e_busy, input logic e_ready,
                                 input int e_step, input bit chk_step);
        check_val("load",    64'(load),        64'(e_load));
        check_val("add",     64'(add),         64'(e_add));
        check_val("sub",     64'(sub),         64'(e_sub));
        check_val("nop",     64'(nop),         64'(e_nop));
        check_val("shift",   64'(shift),       64'(e_shift));
        check_val("restore", 64'(restore),     64'(e_restore));
        check_val("busy",    64'(busy),        64'(e_busy));
        check_val("ready",   64'(ready),       64'(e_ready));
        check_val("dbz",     64'(div_by_zero), 64'(exp_dbz));
        if (chk_step) check_val("step", 64'(step), 64'(e_step));
    endtask

    // One operation, cycle by cycle. Cycle k is the k-th cycle after the
    // edge that sampled start; the expected picture is derived from k alone.
    task automatic run_op(input bit op_div, input bit op_dz, input bit started,
                          input bit chain_next, input bit nd, input bit nz, input bit noise);
        int  lat, st, e_step;
        bit  dz, in_run, in_fix;
        logic e_add, e_sub, e_nop;
        if (!started) begin
            start = 1'b1; is_div = op_div; divisor_zero = op_dz;
            @(posedge clock); #1;
        end
        start = 1'b0;
        dz = op_div & op_dz;
        exp_dbz = dz;
        lat = dz ? 2 : (op_div ? W + 3 : W + 2);
        for (int k = 1; k <= lat; k++) begin
            q0   = 1'($urandom_range(1, 0));
            q_m1 = 1'($urandom_range(1, 0));
            msb  = 1'($urandom_range(1, 0));
            in_run = !dz && (k >= 2) && (k <= W + 1);
            in_fix = op_div && !dz && (k == W + 2);
            st = k - 2;
            if (noise && in_run && ($urandom_range(3, 0) == 0)) begin
                start = 1'b1;
                is_div = 1'($urandom_range(1, 0));
                divisor_zero = 1'($urandom_range(1, 0));
            end else begin
                start = 1'b0;
            end
            if (k == lat && chain_next) begin
                start = 1'b1; is_div = nd; divisor_zero = nz;
            end
            @(negedge clock);
            e_add = 1'b0; e_sub = 1'b0; e_nop = 1'b0;
            if (in_run) begin
                if (op_div) begin
                    if (st == 0 || !msb) e_sub = 1'b1;
                    else e_add = 1'b1;
                end else begin
                    if (q0 == q_m1) e_nop = 1'b1;
                    else if (q0) e_sub = 1'b1;
                    else e_add = 1'b1;
                end
            end
            e_step = in_run ? st : (dz ? 0 : W - 1);
            check_outputs(k == 1, e_add, e_sub, e_nop, in_run, in_fix && msb,
                          k < lat, k == lat, e_step, k != 1);
            @(posedge clock); #1;
        end
        if (!chain_next) start = 1'b0;
    endtask

    task automatic check_idle();
        @(negedge clock);
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        @(posedge clock); #1;
    endtask

    initial begin
        bit cur_d, cur_z, nxt_d, nxt_z, cn, started;
        int lat5, lat32, max5, max32, rdy5, rdy32;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Directed: multiply, divide, divide-by-zero, dbz cleared by multiply
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_idle();
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_idle();
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_idle();
        check_idle();
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_idle();

        // Back-to-back chain through DONE, with ignored starts during RUN
        run_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        run_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_idle();

        // Randomized sequence of operations
        cur_d = 1'($urandom_range(1, 0));
        cur_z = ($urandom_range(3, 0) == 0);
        started = 1'b0;
        for (int i = 0; i < 24; i++) begin
            nxt_d = 1'($urandom_range(1, 0));
            nxt_z = ($urandom_range(3, 0) == 0);
            cn = (i != 23) && ($urandom_range(1, 0) == 1);
            run_op(cur_d, cur_z, started, cn, nxt_d, nxt_z, 1'b1);
            if (!cn) check_idle();
            cur_d = nxt_d; cur_z = nxt_z; started = cn;
        end

        // Reset in the middle of RUN step 3
        start = 1'b1; is_div = 1'b0; divisor_zero = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        q0 = 1'b0; q_m1 = 1'b1;
        check_val("rst_pre_step", 64'(step), 64'd3);
        check_val("rst_pre_busy", 64'(busy), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        exp_dbz = 1'b0;
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        @(posedge clock); #1;
        check_val("rst_hold_ready", 64'(ready), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_idle();

        // WIDTH=5 and WIDTH=32 multiply latency and step peak
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        start = 1'b1; is_div = 1'b0; divisor_zero = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        lat5 = 0; lat32 = 0; max5 = 0; max32 = 0; rdy5 = 0; rdy32 = 0;
        for (int c = 1; c <= 60; c++) begin
            q0 = 1'($urandom_range(1, 0));
            q_m1 = 1'($urandom_range(1, 0));
            @(negedge clock);
            if (ready5) begin rdy5++; if (lat5 == 0) lat5 = c; end
            if (ready32) begin rdy32++; if (lat32 == 0) lat32 = c; end
            if (int'(step5) > max5) max5 = int'(step5);
            if (int'(step32) > max32) max32 = int'(step32);
        end
        check_val("w5_latency",  64'(lat5),  64'd7);
        check_val("w32_latency", 64'(lat32), 64'd34);
        check_val("w5_steppeak", 64'(max5),  64'd4);
        check_val("w32_steppeak", 64'(max32), 64'd31);
        check_val("w5_readycnt", 64'(rdy5),  64'd1);
        check_val("w32_readycnt", 64'(rdy32), 64'd1);
        check_val("w5_stepend",  64'(step5),  64'd4);
        check_val("w32_stepend", 64'(step32), 64'd31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
